// File: rtl/huffman_seq_ctrl.sv
// Sequencer for the canonical Huffman table build: frequency count, length
// generation/limiting, then canonical code assignment, each under a watchdog.
module huffman_seq_ctrl #(
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 1000,
  parameter int RUN_W     = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             freq_done,
  input  logic             len_done,
  input  logic             code_done,
  output logic             freq_start,
  output logic             len_start,
  output logic             code_start,
  output logic             busy,
  output logic             done,
  output logic             table_valid,
  output logic             error,
  output logic [1:0]       err_stage,
  output logic [RUN_W-1:0] run_cycles
);

  typedef enum logic [3:0] {
    S_IDLE, S_FREQ_GO, S_FREQ_WAIT, S_LEN_GO, S_LEN_WAIT,
    S_CODE_GO, S_CODE_WAIT, S_DONE, S_ERR
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [RUN_W-1:0]     RUN_MAX = '1;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic                 tv_q, tv_d;
  logic [1:0]           es_q, es_d;

  // Per-state decode: which done input is live and where a WAIT/GO leads.
  logic                 in_go, in_wait, stage_done;
  logic [1:0]           stage_code;
  state_t               wait_nxt, go_nxt;

  always_comb begin
    in_go      = 1'b0;
    in_wait    = 1'b0;
    stage_done = 1'b0;
    stage_code = 2'd0;
    wait_nxt   = S_IDLE;
    go_nxt     = S_IDLE;
    case (state_q)
      S_FREQ_GO:   begin in_go = 1'b1; go_nxt = S_FREQ_WAIT; end
      S_LEN_GO:    begin in_go = 1'b1; go_nxt = S_LEN_WAIT;  end
      S_CODE_GO:   begin in_go = 1'b1; go_nxt = S_CODE_WAIT; end
      S_FREQ_WAIT: begin
        in_wait = 1'b1; stage_done = freq_done; stage_code = 2'd1; wait_nxt = S_LEN_GO;
      end
      S_LEN_WAIT:  begin
        in_wait = 1'b1; stage_done = len_done;  stage_code = 2'd2; wait_nxt = S_CODE_GO;
      end
      S_CODE_WAIT: begin
        in_wait = 1'b1; stage_done = code_done; stage_code = 2'd3; wait_nxt = S_DONE;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    run_d   = run_q;
    tv_d    = tv_q;
    es_d    = es_q;
    if (abort) begin
      // Cancel leaves err_stage and run_cycles frozen for inspection.
      state_d = S_IDLE;
      tv_d    = 1'b0;
    end else if (in_go || in_wait) begin
      if (run_q != RUN_MAX) run_d = run_q + 1'b1;
      if (in_go) begin
        state_d = go_nxt;
        wdog_d  = '0;
      end else if (stage_done) begin
        state_d = wait_nxt;
        if (wait_nxt == S_DONE) tv_d = 1'b1;
      end else if (wdog_q == WD_LAST) begin
        state_d = S_ERR;
        es_d    = stage_code;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end else if (start) begin
      state_d = S_FREQ_GO;
      tv_d    = 1'b0;
      es_d    = 2'd0;
      run_d   = '0;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wdog_q  <= '0;
      run_q   <= '0;
      tv_q    <= 1'b0;
      es_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      run_q   <= run_d;
      tv_q    <= tv_d;
      es_q    <= es_d;
    end
  end

  assign freq_start  = (state_q == S_FREQ_GO);
  assign len_start   = (state_q == S_LEN_GO);
  assign code_start  = (state_q == S_CODE_GO);
  assign busy        = in_go || in_wait;
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERR);
  assign table_valid = tv_q;
  assign err_stage   = es_q;
  assign run_cycles  = run_q;

endmodule

// File: tb/tb_huffman_seq_ctrl.sv
// Bench for huffman_seq_ctrl: directed scenarios plus random traffic, all
// compared every cycle against a stage-level behavioural model.
module tb_huffman_seq_ctrl;
  localparam int TW   = 16;
  localparam int TO   = 8;
  localparam int RW   = 4;
  localparam int RMAX = (1 << RW) - 1;

  logic clk = 1'b0;
  logic rst, start, abort, fd, ld, cd;
  logic freq_start, len_start, code_start, busy, done, table_valid, error;
  logic [1:0] err_stage;
  logic [RW-1:0] run_cycles;

  int checks = 0;
  int errors = 0;

  // Model: active stage (0 = none, 1..3), whether it is in its start cycle,
  // cycles already spent waiting, plus the visible result registers.
  int m_stage, m_wd, m_es, m_run;
  bit m_go, m_done, m_err, m_tv;

  huffman_seq_ctrl #(.TIMEOUT_W(TW), .TIMEOUT(TO), .RUN_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .freq_done(fd), .len_done(ld), .code_done(cd),
    .freq_start(freq_start), .len_start(len_start), .code_start(code_start),
    .busy(busy), .done(done), .table_valid(table_valid), .error(error),
    .err_stage(err_stage), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stage = 0; m_go = 0; m_wd = 0; m_done = 0; m_err = 0; m_tv = 0; m_es = 0; m_run = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit f, input bit l, input bit c);
    bit sd;
    if (a) begin
      m_stage = 0; m_go = 0; m_done = 0; m_err = 0; m_tv = 0;
      return;
    end
    if (m_stage == 0) begin
      m_done = 0;
      if (s) begin
        m_stage = 1; m_go = 1; m_err = 0; m_tv = 0; m_es = 0; m_run = 0;
      end
      return;
    end
    sd = (m_stage == 1) ? f : (m_stage == 2) ? l : c;
    if (m_run < RMAX) m_run++;
    if (m_go) begin
      m_go = 0; m_wd = 0;
    end else if (sd) begin
      if (m_stage == 3) begin
        m_stage = 0; m_done = 1; m_tv = 1;
      end else begin
        m_stage++; m_go = 1;
      end
    end else if (m_wd == TO - 1) begin
      m_es = m_stage; m_stage = 0; m_err = 1;
    end else begin
      m_wd++;
    end
  endtask

  task automatic compare_all();
    chk("freq_start",  freq_start,  32'(m_stage == 1 && m_go));
    chk("len_start",   len_start,   32'(m_stage == 2 && m_go));
    chk("code_start",  code_start,  32'(m_stage == 3 && m_go));
    chk("busy",        busy,        32'(m_stage != 0));
    chk("done",        done,        32'(m_done));
    chk("error",       error,       32'(m_err));
    chk("table_valid", table_valid, 32'(m_tv));
    chk("err_stage",   err_stage,   32'(m_es));
    chk("run_cycles",  run_cycles,  32'(m_run));
  endtask

  task automatic cyc(input bit s, input bit a, input bit f, input bit l, input bit c);
    start = s; abort = a; fd = f; ld = l; cd = c;
    @(posedge clk);
    model_step(s, a, f, l, c);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; fd = 0; ld = 0; cd = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Minimum-latency run with all dones tied high.
    cyc(1, 0, 1, 1, 1);
    chk("min_freq_start", freq_start, 1);
    repeat (2) cyc(0, 0, 1, 1, 1);
    chk("min_len_start", len_start, 1);
    repeat (2) cyc(0, 0, 1, 1, 1);
    chk("min_code_start", code_start, 1);
    repeat (2) cyc(0, 0, 1, 1, 1);
    chk("min_done", done, 1);
    chk("min_run", run_cycles, 6);
    chk("min_tv", table_valid, 1);
    cyc(0, 0, 0, 0, 0);
    chk("tv_in_idle", table_valid, 1);

    // Asynchronous reset while waiting on the length stage.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    #1 rst = 1'b0;
    cyc(1, 0, 1, 1, 1);
    repeat (6) cyc(0, 0, 1, 1, 1);
    chk("post_rst_done", done, 1);

    // Code stage never answers: watchdog fires after TO CODE_WAIT cycles.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("to_code_start", code_start, 1);
    cyc(0, 0, 0, 0, 0);
    repeat (TO - 1) cyc(0, 0, 0, 0, 0);
    chk("to_not_yet", error, 0);
    cyc(0, 0, 0, 0, 0);
    chk("to_error", error, 1);
    chk("to_err_stage", err_stage, 3);
    chk("to_tv", table_valid, 0);
    chk("to_run_sat", run_cycles, RMAX);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 1);
    chk("restart_err_clr", err_stage, 0);
    repeat (6) cyc(0, 0, 1, 1, 1);
    chk("restart_done", done, 1);

    // len_done on the last permitted LEN_WAIT cycle wins over the timeout.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (TO - 1) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("edge_code_start", code_start, 1);
    chk("edge_no_error", error, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("edge_done", done, 1);

    // freq_done held from before start; stray code_done during LEN_WAIT.
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("held_len_start", len_start, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("stray_code_start", code_start, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("stray_no_done", done, 0);
    cyc(0, 0, 0, 0, 1);
    chk("stray_done", done, 1);

    // Start while busy is ignored; abort in CODE_WAIT freezes run_cycles.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_tv", table_valid, 0);
    chk("abort_run", run_cycles, 6);
    cyc(1, 1, 0, 0, 0);
    chk("abort_start_idle", busy, 0);
    repeat (3) cyc(0, 0, 1, 1, 1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom % 6) == 0, ($urandom % 40) == 0,
          ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
